// File: rtl/sram_like_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto one SRAM-like bus.
// One outstanding transaction; request fields are latched at grant and held until completion.
module sram_like_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner_data;   // 1 = load/store port owns the bus
    logic        r_last_data;    // 1 = load/store port was granted last
    logic        r_bus_wr;
    logic [1:0]  r_bus_size;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_any_req;
    logic        w_grant_data;
    logic        w_bus_req;
    logic        w_addr_ok;
    logic        w_data_ok;

    // A lone requester always wins; ties go to data, or alternate in round-robin mode.
    assign w_any_req    = inst_req | data_req;
    assign w_grant_data = data_req & (~inst_req | DATA_FIRST | ~r_last_data);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_bus_req    = 1'b0;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_bus_req = 1'b1;
                if (bus_addr_ok) begin
                    w_addr_ok    = 1'b1;
                    w_data_ok    = bus_data_ok;
                    w_next_state = bus_data_ok ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    w_data_ok    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // Handshakes are suppressed while reset is held, even before the state register clears.
        if (rst) begin
            w_bus_req = 1'b0;
            w_addr_ok = 1'b0;
            w_data_ok = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_data <= 1'b0;
            r_last_data  <= 1'b0;
            r_bus_wr     <= 1'b0;
            r_bus_size   <= 2'd0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner_data <= w_grant_data;
                r_last_data  <= w_grant_data;
                if (w_grant_data) begin
                    r_bus_wr    <= data_wr;
                    r_bus_size  <= data_size;
                    r_bus_addr  <= data_addr;
                    r_bus_wdata <= data_wdata;
                end else begin
                    r_bus_wr    <= 1'b0;
                    r_bus_size  <= 2'd2;
                    r_bus_addr  <= inst_addr;
                    r_bus_wdata <= 32'd0;
                end
            end
        end
    end

    assign bus_req   = w_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

    assign inst_addr_ok = w_addr_ok & ~r_owner_data;
    assign inst_data_ok = w_data_ok & ~r_owner_data;
    assign data_addr_ok = w_addr_ok &  r_owner_data;
    assign data_data_ok = w_data_ok &  r_owner_data;

    // Read data is a plain pass-through, qualified by the owner's data_ok.
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule
